// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver_if                                                  |
// | Control and pin bundle for the 8-digit seven-segment scan driver.    |
// | master: the debug source (drives value/load/enable/dp)               |
// | slave : the scan driver (drives AN/SEG_C and status)                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg7_scan_driver_if;
  logic        en_i;
  logic        load_i;
  logic [31:0] value_i;
  logic [7:0]  dp_i;
  logic [7:0]  AN;
  logic [7:0]  SEG_C;
  logic        pending_o;
  logic        frame_done_o;

  modport master (
    output en_i, load_i, value_i, dp_i,
    input  AN, SEG_C, pending_o, frame_done_o
  );

  modport slave (
    input  en_i, load_i, value_i, dp_i,
    output AN, SEG_C, pending_o, frame_done_o
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver                                                     |
// | Time-multiplexed 8-digit hex display driver with a double-buffered  |
// | 32-bit value. New values are staged in a pending register and only  |
// | copied to the display register when the scan wraps to digit 0.      |
// | Optional macro SEG7_LZB_EN enables leading-zero blanking.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int TICK_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active-low
  seg7_scan_driver_if.slave  bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICK_DIV - 1);

  // The digit index is the scan state; it cycles S0..S(NUM_DIGITS-1).
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} scan_state_t;
  localparam scan_state_t c_LAST_STATE = scan_state_t'(3'(NUM_DIGITS - 1));

  logic [TICK_W-1:0] r_tick;
  scan_state_t       r_state;
  scan_state_t       w_state_next;
  logic              w_tick_wrap;
  logic              w_frame_wrap;
  logic [31:0]       r_disp;
  logic [31:0]       r_pend;
  logic              r_pflag;
  logic [3:0]        w_nibble;
  logic              w_blank;
  logic [6:0]        w_seg;
  logic [7:0]        w_an;
  logic [7:0]        r_an;
  logic [7:0]        r_seg;
  logic              r_fdone;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_tick_wrap = (r_tick == c_TICK_LAST);

  // Per-digit dwell counter, free-running even while the display is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_tick <= '0;
    else if (w_tick_wrap) r_tick <= '0;
    else                  r_tick <= r_tick + 1'b1;
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S0;
    else      r_state <= w_state_next;
  end

  // Next scan state; flags the frame boundary when the last digit wraps to S0.
  always_comb begin
    w_state_next = r_state;
    w_frame_wrap = 1'b0;
    if (w_tick_wrap) begin
      if (r_state == c_LAST_STATE) begin
        w_state_next = S0;
        w_frame_wrap = 1'b1;
      end else begin
        w_state_next = scan_state_t'(r_state + 3'd1);
      end
    end
  end

  // Double buffer: a load coincident with a wrap still promotes the older
  // pending value, and the new one stays pending for the following frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp  <= '0;
      r_pend  <= '0;
      r_pflag <= 1'b0;
    end else begin
      if (w_frame_wrap && r_pflag) r_disp <= r_pend;
      if (bus.load_i) begin
        r_pend  <= bus.value_i;
        r_pflag <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pflag <= 1'b0;
      end
    end
  end

  assign w_nibble = r_disp[{r_state, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
  logic [7:0] w_zero_from;  // bit k: nibbles k..NUM_DIGITS-1 are all zero
  logic       w_run_zero;

  // Leading-zero mask from the display register, so it only moves at frame boundaries.
  always_comb begin
    w_zero_from = '1;
    w_run_zero  = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      if (k < NUM_DIGITS) w_run_zero = w_run_zero && (r_disp[4*k +: 4] == 4'h0);
      w_zero_from[k] = w_run_zero;
    end
  end

  assign w_blank = (r_state != S0) && w_zero_from[r_state];
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg = w_blank ? 7'h7F : f_hex_to_seg(w_nibble);
  assign w_an  = bus.en_i ? ~(8'h01 << r_state) : 8'hFF;

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an    <= 8'hFF;
      r_seg   <= 8'hFF;
      r_fdone <= 1'b0;
    end else begin
      r_an    <= w_an;
      r_seg   <= {~bus.dp_i[r_state], w_seg};
      r_fdone <= w_frame_wrap;
    end
  end

  assign bus.AN           = r_an;
  assign bus.SEG_C        = r_seg;
  assign bus.pending_o    = r_pflag;
  assign bus.frame_done_o = r_fdone;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_driver                                                  |
// | Directed scenarios plus random traffic against a cycle-count based  |
// | reference model of the scan driver.                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seg7_scan_driver;
  localparam int TD = 4;
  localparam int ND = 8;
  localparam int FRAME = TD * ND;

  logic clk = 1'b0;
  logic rst;
  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.TICK_DIV(TD), .NUM_DIGITS(ND)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] enc_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: edges since reset release and the two buffers.
  int          m_n;
  logic [31:0] m_disp, m_pend;
  bit          m_pflag;
  logic [7:0]  exp_an, exp_seg;
  bit          exp_fd, exp_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 1; m_disp = '0; m_pend = '0; m_pflag = 0;
  endtask

  function automatic int next_idx();
    return ((m_n - 1) / TD) % ND;
  endfunction

  // Expected outputs after the edge are a function of the digit shown
  // before it; the buffers then update from the inputs seen at that edge.
  task automatic model_edge();
    int          idx;
    logic [31:0] upper;
    logic [6:0]  s7;
    bit          wrap;
    idx    = next_idx();
    exp_an = bus.en_i ? ~(8'h01 << idx) : 8'hFF;
    upper  = m_disp >> (4 * idx);
    s7     = enc_tab[upper[3:0]][6:0];
`ifdef SEG7_LZB_EN
    if (idx > 0 && upper == 32'd0) s7 = 7'h7F;
`endif
    exp_seg = {~bus.dp_i[idx], s7};
    wrap    = (m_n % FRAME) == 0;
    exp_fd  = wrap;
    if (wrap && m_pflag) m_disp = m_pend;
    if (wrap) m_pflag = 0;
    if (bus.load_i) begin
      m_pend  = bus.value_i;
      m_pflag = 1;
    end
    exp_pend = m_pflag;
    m_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("an", bus.AN, exp_an);
    check_eq("seg", bus.SEG_C, exp_seg);
    check_eq("pending", bus.pending_o, exp_pend);
    check_eq("frame_done", bus.frame_done_o, exp_fd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, bus.AN, 8'hFF);
    check_eq({tag, "_seg"}, bus.SEG_C, 8'hFF);
    check_eq({tag, "_pend"}, bus.pending_o, 1'b0);
    check_eq({tag, "_fd"}, bus.frame_done_o, 1'b0);
  endtask

  task automatic wait_idx(input int k);
    int guard = 0;
    while (next_idx() != k && guard < 2 * FRAME) begin
      step();
      guard++;
    end
  endtask

  task automatic load(input logic [31:0] v);
    bus.load_i = 1'b1; bus.value_i = v;
    step();
    bus.load_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.en_i = 1'b1; bus.load_i = 1'b0; bus.value_i = '0; bus.dp_i = '0;
    model_reset();

    // Reset held for three clocks.
    repeat (3) begin
      @(posedge clk); #1;
      check_reset_outputs("rst_hold");
    end
    #2 rst = 1'b1;
    model_reset();
    step();
    check_eq("an_first", bus.AN, 8'hFE);
    check_eq("seg_first", bus.SEG_C, 8'hC0);
    repeat (4) step();
    check_eq("an_digit1", bus.AN, 8'hFD);
    check_eq("seg_digit1", bus.SEG_C, 8'hC0);

    // Mid-frame load at digit 3.
    wait_idx(3);
    load(32'h1234ABCD);
    check_eq("pend_set", bus.pending_o, 1'b1);
    repeat (2 * FRAME) step();

    // Two loads inside one frame: the last one wins.
    wait_idx(1);
    load(32'h11111111);
    repeat (3) step();
    load(32'h22222222);
    repeat (2 * FRAME) step();

    // Asynchronous reset with a value pending.
    wait_idx(2);
    load(32'h5A5A5A5A);
    step();
    check_eq("pend_before_rst", bus.pending_o, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    #2 rst = 1'b1;
    model_reset();
    repeat (FRAME) step();

    // Disabled for ten clocks; the scan keeps running underneath.
    bus.en_i = 1'b0;
    repeat (10) step();
    bus.en_i = 1'b1;
    repeat (FRAME) step();

    // Decimal point on digit 0 with a zero display.
    bus.dp_i = 8'h01;
    wait_idx(0);
    step();
    check_eq("dp_an", bus.AN, 8'hFE);
    check_eq("dp_seg", bus.SEG_C, 8'h40);
    bus.dp_i = 8'h00;

    // Value with leading zeros.
    wait_idx(5);
    load(32'h000000A5);
    repeat (2 * FRAME) step();

    // Load landing exactly on the frame boundary with an older value pending.
    wait_idx(6);
    load(32'hCAFE0001);
    for (int i = 0; i < FRAME && (m_n % FRAME) != 0; i++) step();
    load(32'h0BAD00F0);
    check_eq("pend_coincident", bus.pending_o, 1'b1);
    repeat (2 * FRAME) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.en_i    = ($urandom_range(0, 9) != 0);
      bus.dp_i    = 8'($urandom);
      bus.load_i  = ($urandom_range(0, 11) == 0);
      bus.value_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
      step();
    end
    bus.load_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
